ssd_scan_scheduler: RTL

//  Sequences the multiplexed seven-segment display (SSD) of the key/display peripheral: per-digit dwell timing,

---
 rtl/ssd_scan_scheduler_pkg.sv | 6 +
 rtl/ssd_scan_scheduler_if.sv | 23 ++
 rtl/ssd_scan_scheduler_pwm_gen.sv | 24 ++
 rtl/ssd_scan_scheduler.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ssd_scan_scheduler_pkg.sv
// ssd_scan_scheduler_pkg: shared types and constants for the seven-segment scan scheduler
package ssd_scan_scheduler_pkg;
  typedef enum logic [1:0] {SSD_IDLE, SSD_BLANK, SSD_ON} SsdState_t;
  typedef logic [7:0] SegCode_t;
  localparam SegCode_t SEG_OFF = 8'hFF;
endpackage

// File: rtl/ssd_scan_scheduler_if.sv
// ssd_scan_scheduler_if: frame source / brightness inputs and display pin outputs of the scan scheduler
interface ssd_scan_scheduler_if #(
  parameter int NUM_DIGITS = 6,
  parameter int BRIGHT_W   = 4
);
  logic                    Enable;
  logic                    FrameWrEn;
  logic [8*NUM_DIGITS-1:0] FrameSeg;
  logic [BRIGHT_W-1:0]     Brightness;
  logic [7:0]              Segment;
  logic [NUM_DIGITS-1:0]   Digital;
  logic [2:0]              DigitIndex;
  logic                    FrameDone;
  logic                    FramePend;
  modport master (
    output Enable, FrameWrEn, FrameSeg, Brightness,
    input  Segment, Digital, DigitIndex, FrameDone, FramePend
  );
  modport slave (
    input  Enable, FrameWrEn, FrameSeg, Brightness,
    output Segment, Digital, DigitIndex, FrameDone, FramePend
  );
endinterface

// File: rtl/ssd_scan_scheduler_pwm_gen.sv
// ssd_scan_scheduler_pwm_gen: per-digit brightness latch and PWM lit decision
module ssd_scan_scheduler_pwm_gen #(
  parameter int BRIGHT_W = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Load,
  input  logic [BRIGHT_W-1:0] Brightness,
  output logic                Lit
);
  logic [BRIGHT_W-1:0] brReg;
  logic [BRIGHT_W-1:0] pwmCnt;
  // Latch brightness at the start of each ON phase and restart the duty counter there
  always_ff @(posedge Clock) begin
    if (Reset) begin
      brReg  <= '0;
      pwmCnt <= '0;
    end else begin
      brReg  <= Load ? Brightness : brReg;
      pwmCnt <= Load ? '0 : pwmCnt + 1'b1;
    end
  end
  assign Lit = (brReg == '1) || (pwmCnt < brReg);
endmodule

// File: rtl/ssd_scan_scheduler.sv
// ssd_scan_scheduler: multiplexed seven-segment scan with blanking, PWM brightness and double-buffered frames
module ssd_scan_scheduler
  import ssd_scan_scheduler_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BRIGHT_W     = 4
) (
  input logic             Clock,
  input logic             Reset,
  ssd_scan_scheduler_if.slave bus
);
  localparam int TMR_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] TMR_DWELL = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] TMR_BLANK = TW'(BLANK_CYCLES - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gBadDigits
    $error("NUM_DIGITS must be 1..8");
  end
  if (DWELL_CYCLES < (1 << BRIGHT_W)) begin : gBadDwell
    $error("DWELL_CYCLES must cover a full PWM period");
  end
  if (BLANK_CYCLES < 1) begin : gBadBlank
    $error("BLANK_CYCLES must be at least 1");
  end

  SsdState_t st, stNxt;
  logic [TW-1:0] tmr, tmrNxt;
  logic [2:0] digIdx, digIdxNxt;
  logic pwmLoad, frameSwap, frameEnd, lit;
  logic [8*NUM_DIGITS-1:0] shadowFrame, activeFrame;
  logic framePend;
  SegCode_t segReg;
  logic [NUM_DIGITS-1:0] digReg;
  logic doneReg;

  ssd_scan_scheduler_pwm_gen #(.BRIGHT_W(BRIGHT_W)) uPwm (
    .Clock      (Clock),
    .Reset      (Reset),
    .Load       (pwmLoad),
    .Brightness (bus.Brightness),
    .Lit        (lit)
  );

  // State, dwell/blank timer and digit pointer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st     <= SSD_IDLE;
      tmr    <= '0;
      digIdx <= '0;
    end else begin
      st     <= stNxt;
      tmr    <= tmrNxt;
      digIdx <= digIdxNxt;
    end
  end

  // Scan sequencing; dropping Enable always parks in IDLE without ending the frame
  always_comb begin
    stNxt     = st;
    tmrNxt    = tmr;
    digIdxNxt = digIdx;
    pwmLoad   = 1'b0;
    frameSwap = 1'b0;
    frameEnd  = 1'b0;
    case (st)
      SSD_IDLE: begin
        frameSwap = 1'b1;
        if (bus.Enable) begin
          stNxt     = SSD_BLANK;
          tmrNxt    = TMR_BLANK;
          digIdxNxt = '0;
        end
      end
      SSD_BLANK: begin
        if (!bus.Enable) begin
          stNxt     = SSD_IDLE;
          digIdxNxt = '0;
        end else if (tmr == '0) begin
          stNxt   = SSD_ON;
          tmrNxt  = TMR_DWELL;
          pwmLoad = 1'b1;
        end else begin
          tmrNxt = tmr - 1'b1;
        end
      end
      SSD_ON: begin
        if (!bus.Enable) begin
          stNxt     = SSD_IDLE;
          digIdxNxt = '0;
        end else if (tmr == '0) begin
          stNxt     = SSD_BLANK;
          tmrNxt    = TMR_BLANK;
          frameEnd  = (digIdx == LAST_DIGIT);
          frameSwap = frameEnd;
          digIdxNxt = frameEnd ? 3'd0 : digIdx + 3'd1;
        end else begin
          tmrNxt = tmr - 1'b1;
        end
      end
      default: stNxt = SSD_IDLE;
    endcase
  end

  // Double buffer: writes land in shadow and are promoted only at a frame boundary; a write on that boundary goes straight to active
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadowFrame <= '1;
      activeFrame <= '1;
      framePend   <= 1'b0;
    end else begin
      shadowFrame <= bus.FrameWrEn ? bus.FrameSeg : shadowFrame;
      activeFrame <= (bus.FrameWrEn && frameSwap) ? bus.FrameSeg :
                     (framePend && frameSwap)     ? shadowFrame  : activeFrame;
      framePend   <= bus.FrameWrEn ? !frameSwap : framePend && !frameSwap;
    end
  end

  // Pin registers follow the state register by one cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      segReg  <= SEG_OFF;
      digReg  <= '1;
      doneReg <= 1'b0;
    end else begin
      segReg  <= (st == SSD_ON && lit) ? activeFrame[{digIdx, 3'b000} +: 8] : SEG_OFF;
      digReg  <= (st == SSD_ON) ? ~(NUM_DIGITS'(1) << digIdx) : '1;
      doneReg <= frameEnd;
    end
  end

  assign bus.Segment    = segReg;
  assign bus.Digital    = digReg;
  assign bus.DigitIndex = digIdx;
  assign bus.FrameDone  = doneReg;
  assign bus.FramePend  = framePend;
endmodule
